// File: rtl/johnson_pkg.sv
// Shared types and constants for the 4-bit Johnson code decoder.
// Holds the code-to-index table so the LUT and any consumer agree on one encoding.
package johnson_pkg;

    typedef enum logic {HUNT, LOCKED} state_t;

    localparam int JC_LEN   = 8;
    localparam int JC_IDX_W = $clog2(JC_LEN);

    // Indexed by the raw 4-bit code; each entry is {legal, idx[2:0]}.
    localparam logic [3:0] JC_LUT [16] = '{
        4'h8, 4'h9, 4'h0, 4'hA,   // 0000->0, 0001->1, 0010 bad, 0011->2
        4'h0, 4'h0, 4'h0, 4'hB,   // 0100..0110 bad, 0111->3
        4'hF, 4'h0, 4'h0, 4'h0,   // 1000->7, 1001..1011 bad
        4'hE, 4'h0, 4'hD, 4'hC    // 1100->6, 1101 bad, 1110->5, 1111->4
    };

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/johnson_lut.sv
// Purpose: combinational Johnson code to sequence index decode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluates every cycle.
module johnson_lut
    import johnson_pkg::*;
(
    input  logic [3:0]          in_code,
    output logic [JC_IDX_W-1:0] idx,
    output logic                legal
);

    logic [3:0] ent;

    assign ent   = JC_LUT[in_code];
    assign legal = ent[3];
    assign idx   = ent[JC_IDX_W-1:0];

endmodule

// File: rtl/johnson_dec4.sv
// Purpose: decode a Johnson code stream, track in-sequence lock and count errors.
// Latency: 1 cycle from in_valid to out_valid; all outputs registered.
// Backpressure: none; every valid sample is consumed and reported.
module johnson_dec4
    import johnson_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 3
) (
    input  logic                jk_clk,
    input  logic                jk_rs,
    input  logic                in_valid,
    input  logic [3:0]          in_code,
    output logic                out_valid,
    output logic [JC_IDX_W-1:0] out_idx,
    output logic                out_illegal,
    output logic                out_seq_err,
    output logic                locked,
    output logic [7:0]          err_cnt
);

    localparam logic [2:0] LOCK_RUN = 3'(LOCK_CNT);

    logic [JC_IDX_W-1:0] lut_idx;
    logic                lut_legal;

    state_t              state;
    logic [JC_IDX_W-1:0] prev_idx;
    logic                prev_ok;
    logic [2:0]          run;

    logic                is_adv;
    logic                is_stall;
    logic [2:0]          hunt_run;

    johnson_lut u_lut (
        .in_code (in_code),
        .idx     (lut_idx),
        .legal   (lut_legal)
    );

    // 3-bit add wraps 7->0, so the wrap counts as an advance.
    always_comb begin
        is_adv   = prev_ok && (lut_idx == prev_idx + 3'd1);
        is_stall = prev_ok && (lut_idx == prev_idx);
        hunt_run = 3'd1;
        if (is_adv) begin
            hunt_run = run + 3'd1;
        end else if (is_stall) begin
            hunt_run = run;
        end
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge jk_clk or negedge jk_rs) begin
        if (!jk_rs) begin
            out_valid   <= 1'b0;
            out_idx     <= '0;
            out_illegal <= 1'b0;
            out_seq_err <= 1'b0;
            err_cnt     <= '0;
            prev_idx    <= '0;
            prev_ok     <= 1'b0;
            run         <= '0;
            state       <= HUNT;
        end else begin
            out_valid   <= in_valid;
            out_illegal <= 1'b0;
            out_seq_err <= 1'b0;
            if (in_valid) begin
                if (!lut_legal) begin
                    out_illegal <= 1'b1;
                    err_cnt     <= sat_inc8(err_cnt);
                    state       <= HUNT;
                    run         <= '0;
                    prev_ok     <= 1'b0;
                end else begin
                    out_idx  <= lut_idx;
                    prev_idx <= lut_idx;
                    prev_ok  <= 1'b1;
                    case (state)
                        HUNT: begin
                            if (hunt_run == LOCK_RUN) begin
                                state <= LOCKED;
                                run   <= '0;
                            end else begin
                                run <= hunt_run;
                            end
                        end
                        LOCKED: begin
                            if (!is_adv && !is_stall) begin
                                out_seq_err <= 1'b1;
                                err_cnt     <= sat_inc8(err_cnt);
                                state       <= HUNT;
                                run         <= 3'd1;
                            end
                        end
                        default: state <= HUNT;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_dec4.sv
// Bench for johnson_dec4: directed scenarios plus random stream against a
// sequence-level reference model.
module tb_johnson_dec4;

    localparam int LOCK_CNT = 3;
    localparam logic [3:0] JC_SEQ [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                           4'b1111, 4'b1110, 4'b1100, 4'b1000};

    logic       jk_clk;
    logic       jk_rs;
    logic       in_valid;
    logic [3:0] in_code;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       out_illegal;
    logic       out_seq_err;
    logic       locked;
    logic [7:0] err_cnt;

    johnson_dec4 #(.LOCK_CNT(LOCK_CNT)) dut (
        .jk_clk      (jk_clk),
        .jk_rs       (jk_rs),
        .in_valid    (in_valid),
        .in_code     (in_code),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .out_illegal (out_illegal),
        .out_seq_err (out_seq_err),
        .locked      (locked),
        .err_cnt     (err_cnt)
    );

    initial jk_clk = 1'b0;
    always #5 jk_clk = ~jk_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, expressed as sequence positions and a run length.
    bit m_vld, m_ill, m_seq, m_locked, m_have_prev;
    int m_idx, m_prev, m_run, m_err;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int jc_index(input logic [3:0] c);
        for (int i = 0; i < 8; i++) if (JC_SEQ[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_vld = 0; m_ill = 0; m_seq = 0; m_locked = 0; m_have_prev = 0;
        m_idx = 0; m_prev = 0; m_run = 0; m_err = 0;
    endtask

    task automatic model_update(input bit v, input logic [3:0] c);
        int k;
        m_vld = v; m_ill = 0; m_seq = 0;
        if (!v) return;
        k = jc_index(c);
        if (k < 0) begin
            m_ill = 1; m_locked = 0; m_run = 0; m_have_prev = 0;
        end else begin
            bit adv, stall;
            adv   = m_have_prev && (k == (m_prev + 1) % 8);
            stall = m_have_prev && (k == m_prev);
            m_idx = k;
            if (!m_locked) begin
                if (adv)        m_run = m_run + 1;
                else if (!stall) m_run = 1;
                if (m_run == LOCK_CNT) begin
                    m_locked = 1; m_run = 0;
                end
            end else if (!adv && !stall) begin
                m_seq = 1; m_locked = 0; m_run = 1;
            end
            m_prev = k; m_have_prev = 1;
        end
        if ((m_ill || m_seq) && m_err < 255) m_err++;
    endtask

    task automatic step(input bit v, input logic [3:0] c);
        in_valid = v;
        in_code  = c;
        @(posedge jk_clk);
        model_update(v, c);
        @(negedge jk_clk);
        chk("out_valid",   out_valid,   m_vld);
        chk("out_idx",     out_idx,     m_idx);
        chk("out_illegal", out_illegal, m_ill);
        chk("out_seq_err", out_seq_err, m_seq);
        chk("locked",      locked,      m_locked);
        chk("err_cnt",     err_cnt,     m_err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},   out_valid,   0);
        chk({tag, "_idx"},     out_idx,     0);
        chk({tag, "_illegal"}, out_illegal, 0);
        chk({tag, "_seq_err"}, out_seq_err, 0);
        chk({tag, "_locked"},  locked,      0);
        chk({tag, "_err_cnt"}, err_cnt,     0);
    endtask

    // Called just after a falling edge: reset lands between clock edges.
    task automatic async_reset(input string tag);
        #2 jk_rs = 1'b0;
        #1 chk_all_zero(tag);
        model_reset();
        @(negedge jk_clk);
        jk_rs = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur;
        logic [3:0] code;
        int r;

        in_valid = 1'b0;
        in_code  = 4'b0000;
        jk_rs    = 1'b1;
        model_reset();
        #1 jk_rs = 1'b0;
        repeat (2) @(negedge jk_clk);
        chk_all_zero("reset");
        jk_rs = 1'b1;

        // First edge after release with no valid sample.
        step(1'b0, 4'b0000);

        // Clean stream 0..7,0.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, JC_SEQ[i % 8]);
            chk("clean_idx",  out_idx, i % 8);
            chk("clean_lock", locked,  (i >= LOCK_CNT - 1) ? 1 : 0);
        end
        chk("clean_err", err_cnt, 0);

        // Illegal injection while locked, then relock.
        step(1'b1, 4'b0101);
        chk("ill_pulse", out_illegal, 1);
        chk("ill_lock",  locked,      0);
        chk("ill_err",   err_cnt,     1);
        step(1'b1, JC_SEQ[1]);
        chk("ill_pulse_end", out_illegal, 0);
        step(1'b1, JC_SEQ[2]);
        step(1'b1, JC_SEQ[3]);
        chk("ill_relock", locked, 1);

        // Walk to idx 2 while locked, then jump to idx 5.
        for (int i = 4; i <= 10; i++) step(1'b1, JC_SEQ[i % 8]);
        chk("pre_jump_lock", locked, 1);
        chk("pre_jump_idx",  out_idx, 2);
        step(1'b1, 4'b1110);
        chk("jump_seq_err", out_seq_err, 1);
        chk("jump_illegal", out_illegal, 0);
        chk("jump_lock",    locked,      0);
        chk("jump_err",     err_cnt,     2);
        step(1'b1, 4'b1100);
        step(1'b1, 4'b1000);
        step(1'b1, 4'b0000);
        chk("jump_relock", locked, 1);

        // Stalls with gaps.
        step(1'b1, 4'b0001);
        step(1'b1, 4'b0011);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b0111);
            chk("stall_lock", locked, 1);
            step(1'b0, 4'b1010);
            chk("gap_valid", out_valid, 0);
            chk("gap_idx",   out_idx,   3);
        end
        chk("stall_err", err_cnt, 2);

        // Random stream, mostly in-sequence so locks form and break often.
        cur = 0;
        for (int n = 0; n < 2000; n++) begin
            if (n == 700 || n == 1400) begin
                async_reset("rand_rst");
                step(1'b0, 4'b0000);
            end
            r = $urandom_range(0, 99);
            if (r < 60) begin
                cur = (cur + 1) % 8; code = JC_SEQ[cur];
            end else if (r < 72) begin
                code = JC_SEQ[cur];
            end else if (r < 82) begin
                cur = $urandom_range(0, 7); code = JC_SEQ[cur];
            end else begin
                code = 4'($urandom_range(0, 15));
                if (jc_index(code) >= 0) cur = jc_index(code);
            end
            step(($urandom_range(0, 9) != 0), code);
        end

        // Saturation.
        for (int i = 0; i < 300; i++) step(1'b1, 4'b0101);
        chk("sat_err", err_cnt, 255);
        step(1'b1, 4'b1011);
        step(1'b1, 4'b0011);
        step(1'b1, 4'b1110);
        chk("sat_hold", err_cnt, 255);

        // Mid-stream reset drops everything at once.
        step(1'b1, 4'b1100);
        step(1'b1, 4'b1000);
        chk("pre_rst_lock", locked, 1);
        in_valid = 1'b1;
        async_reset("mid_rst");
        step(1'b1, 4'b0000);
        chk("post_rst_lock", locked, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
